bcd_div11_stream_ctrl: RTL and testbench

//  Sequencing controller for divisibility-by-11 checks on BCD numbers longer than one 16-bit word.

---
 rtl/bcd_pkg.sv | 21 ++
 rtl/bcd_word_mod11.sv | 27 ++
 rtl/bcd_div11_stream_ctrl.sv | 104 ++++++++++
 tb/tb_bcd_div11_stream_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD divisibility-by-11 datapath.
package bcd_pkg;

    localparam int BCD_DIGIT_MAX = 9;
    localparam int MOD11         = 11;

    typedef logic [3:0]       bcd_digit_t;
    // Element 0 is the least significant digit (bits [3:0]).
    typedef bcd_digit_t [3:0] bcd_word_t;

    // Modular add of two residues that are both already in 0..10.
    function automatic logic [3:0] mod11_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= 5'(MOD11)) begin
            sum = sum - 5'(MOD11);
        end
        return sum[3:0];
    endfunction

endpackage

// File: rtl/bcd_word_mod11.sv
// Residue mod 11 of one 4-digit word. Because 10^4 = 1 (mod 11), each word's
// residue can be folded into the running total independently of its position.
module bcd_word_mod11
    import bcd_pkg::*;
(
    input  bcd_word_t  word,
    output logic [3:0] rem,
    output logic       bad
);

    logic [5:0] raw;

    // Alternating digit sum, offset by 33 so the 6-bit value never underflows.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path,
        // otherwise synthesis infers a latch to hold the old one.
        bad = 1'b0;
        raw = 6'(word[0]) + 6'(word[2]) + 6'd33 - 6'(word[1]) - 6'(word[3]);
        rem = 4'(raw % 6'(MOD11));
        for (int i = 0; i < 4; i++) begin
            if (word[i] > 4'(BCD_DIGIT_MAX)) begin
                bad = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bcd_div11_stream_ctrl.sv
// Streaming divisibility-by-11 controller: accumulates word residues of a
// multi-word BCD number (MS word first) and presents one held result per number.
module bcd_div11_stream_ctrl
    import bcd_pkg::*;
#(
    parameter int CNT_W      = 8,
    parameter bit STRICT_BCD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_rem,
    output logic             out_div11,
    output logic             out_bad,
    output logic [CNT_W-1:0] out_words
);

    localparam logic [0:0] ST_ACCUM  = 1'b0;
    localparam logic [0:0] ST_RESULT = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [0:0]       state;
    logic [3:0]       acc;
    logic             bad;
    logic [CNT_W-1:0] cnt;

    logic [3:0]       word_rem;
    logic             word_bad;
    logic [3:0]       acc_nxt;
    logic             bad_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;

    bcd_word_mod11 u_word_mod11 (
        .word (bcd_word_t'(in_data)),
        .rem  (word_rem),
        .bad  (word_bad)
    );

    // No skid buffer: a word is only taken while collecting and not being cleared.
    assign in_ready = (state == ST_ACCUM) && !clear;
    assign accept   = in_valid && in_ready;

    // Running totals including the word on the input this cycle.
    always_comb begin
        acc_nxt = mod11_add(acc, word_rem);
        bad_nxt = bad | word_bad;
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    end

    // Controller, accumulator and result registers.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state     <= ST_ACCUM;
            acc       <= '0;
            bad       <= 1'b0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_rem   <= '0;
            out_div11 <= 1'b0;
            out_bad   <= 1'b0;
            out_words <= '0;
        end else if (state == ST_ACCUM) begin
            if (clear) begin
                acc <= '0;
                bad <= 1'b0;
                cnt <= '0;
            end else if (accept) begin
                if (in_last) begin
                    // The result includes the last word; totals restart for the next number.
                    state     <= ST_RESULT;
                    out_valid <= 1'b1;
                    out_rem   <= acc_nxt;
                    out_div11 <= (acc_nxt == 4'd0) && !(STRICT_BCD && bad_nxt);
                    out_bad   <= bad_nxt;
                    out_words <= cnt_nxt;
                    acc       <= '0;
                    bad       <= 1'b0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_nxt;
                    bad <= bad_nxt;
                    cnt <= cnt_nxt;
                end
            end
        end else begin
            // A completed result is held until consumed; clear is ignored here.
            if (out_ready) begin
                state     <= ST_ACCUM;
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bcd_div11_stream_ctrl.sv
// Randomized bench for bcd_div11_stream_ctrl. Two instances share the stimulus:
// the default configuration and a short-counter, non-strict configuration.
module tb_bcd_div11_stream_ctrl;

    typedef logic [15:0] wq_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;

    logic       rdy_a, val_a, div_a, bad_a;
    logic [3:0] rem_a;
    logic [7:0] words_a;
    logic       rdy_b, val_b, div_b, bad_b;
    logic [3:0] rem_b;
    logic [1:0] words_b;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bcd_div11_stream_ctrl #(.CNT_W(8), .STRICT_BCD(1'b1)) dut_a (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (rdy_a),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (val_a),
        .out_ready (out_ready),
        .out_rem   (rem_a),
        .out_div11 (div_a),
        .out_bad   (bad_a),
        .out_words (words_a)
    );

    bcd_div11_stream_ctrl #(.CNT_W(2), .STRICT_BCD(1'b0)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (rdy_b),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (val_b),
        .out_ready (out_ready),
        .out_rem   (rem_b),
        .out_div11 (div_b),
        .out_bad   (bad_b),
        .out_words (words_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference: treat the words as one decimal number (digit weights 1000/100/10/1,
    // 10^4 per word) and reduce mod 11 with ordinary integer arithmetic.
    function automatic int model_rem(input wq_t q);
        int r = 0;
        foreach (q[i]) begin
            r = (r * 10000 + int'(q[i][15:12]) * 1000 + int'(q[i][11:8]) * 100
                 + int'(q[i][7:4]) * 10 + int'(q[i][3:0])) % 11;
        end
        return r;
    endfunction

    function automatic bit model_bad(input wq_t q);
        foreach (q[i]) begin
            for (int k = 0; k < 4; k++) begin
                if (((q[i] >> (4 * k)) & 16'hF) > 16'd9) return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    function automatic logic [15:0] rand_word();
        logic [15:0] w = '0;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 9) == 0) w[4*k +: 4] = 4'($urandom_range(10, 15));
            else                           w[4*k +: 4] = 4'($urandom_range(0, 9));
        end
        return w;
    endfunction

    task automatic check_reset_outputs();
        check("rst_val_a", val_a, 0);   check("rst_val_b", val_b, 0);
        check("rst_rem_a", rem_a, 0);   check("rst_rem_b", rem_b, 0);
        check("rst_div_a", div_a, 0);   check("rst_div_b", div_b, 0);
        check("rst_bad_a", bad_a, 0);   check("rst_bad_b", bad_b, 0);
        check("rst_words_a", words_a, 0); check("rst_words_b", words_b, 0);
        check("rst_rdy_a", rdy_a, 1);   check("rst_rdy_b", rdy_b, 1);
    endtask

    task automatic check_result(input wq_t q);
        int r = model_rem(q);
        bit b = model_bad(q);
        int n = q.size();
        check("val_a", val_a, 1);
        check("rem_a", rem_a, r);
        check("div_a", div_a, (r == 0) && !b);
        check("bad_a", bad_a, b);
        check("words_a", words_a, (n > 255) ? 255 : n);
        check("val_b", val_b, 1);
        check("rem_b", rem_b, r);
        check("div_b", div_b, r == 0);
        check("bad_b", bad_b, b);
        check("words_b", words_b, (n > 3) ? 3 : n);
    endtask

    // Offer one word and hold it until accepted (bounded); returns just after the accepting edge.
    task automatic send_word(input logic [15:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        #1;
        while (!rdy_a && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_a", rdy_a, 1);
        check("in_ready_b", rdy_b, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'($urandom);
    endtask

    // Called right after the last-word edge: result must already be visible,
    // then held through the stall (clear may pulse), then consumed.
    task automatic finish_number(input wq_t q, input int stall);
        @(negedge clk);
        check_result(q);
        for (int k = 0; k < stall; k++) begin
            clear = 1'($urandom_range(0, 1));
            @(negedge clk);
            check_result(q);
            check("stall_rdy_a", rdy_a, 0);
            check("stall_rdy_b", rdy_b, 0);
        end
        clear     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("done_val_a", val_a, 0);
        check("done_val_b", val_b, 0);
        check("next_rdy_a", rdy_a, 1);
        check("next_rdy_b", rdy_b, 1);
    endtask

    task automatic run_number(input wq_t q, input int gap_max, input int stall);
        foreach (q[i]) begin
            int g = $urandom_range(0, gap_max);
            if (g > 0) begin
                repeat (g) @(posedge clk);
                #1;
            end
            send_word(q[i], i == q.size() - 1);
        end
        finish_number(q, stall);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_reset_outputs();
    endtask

    initial begin
        wq_t q;
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs();

        // Directed cases.
        q = '{16'h1221};               run_number(q, 0, 0);
        q = '{16'h1234};               run_number(q, 0, 0);
        q = '{16'h0001, 16'h0010};     run_number(q, 0, 0);
        q = '{16'h0001, 16'h0001};     run_number(q, 0, 0);
        q = '{16'h12A4};               run_number(q, 0, 0);
        q = '{16'h0303, 16'h9999};     run_number(q, 0, 3);

        // clear mid-number drops the partial number and the word offered with it.
        send_word(16'h0005, 1'b0);
        send_word(16'h0007, 1'b0);
        clear = 1'b1; in_valid = 1'b1; in_data = 16'h1111; in_last = 1'b1;
        #1;
        check("clear_rdy_a", rdy_a, 0);
        check("clear_rdy_b", rdy_b, 0);
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        q = '{16'h0121};               run_number(q, 0, 0);

        // Reset mid-number, then reset while a result is pending.
        send_word(16'h0042, 1'b0);
        send_word(16'h0017, 1'b0);
        pulse_rst();
        q = '{16'h0121};               run_number(q, 0, 0);
        send_word(16'h0100, 1'b1);
        @(negedge clk);
        check("pend_val_a", val_a, 1);
        pulse_rst();
        q = '{16'h0121};               run_number(q, 0, 0);

        // Long number: counter saturation with an exact residue.
        q.delete();
        repeat (300) q.push_back(rand_word());
        run_number(q, 0, 0);

        // Randomized numbers, some preceded by an abandoned partial number.
        repeat (60) begin
            if ($urandom_range(0, 5) == 0) begin
                repeat ($urandom_range(1, 2)) send_word(rand_word(), 1'b0);
                clear = 1'b1;
                @(posedge clk); #1;
                clear = 1'b0;
            end
            q.delete();
            repeat ($urandom_range(1, 6)) q.push_back(rand_word());
            run_number(q, 2, $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
